ul4_arbiter: RTL and testbench

- Round-robin controller that shares a single 4-bit logic unit (ul4: operands a, b, 2-bit selector s, combinational result Out) between two requesters.
- Accepts one operation at a time through a valid/ready handshake and drives the logic unit's operand and selector inputs from internal registers.
- Samples the logic unit's result and returns it, tagged with the requester id, through a result handshake with backpressure.
- Sits between the requester blocks and the ul4 instance. The ul4 stays a separate instance, wired to the ul_* ports.

---
 rtl/ul4_arbiter.sv | 141 ++++++++++++++
 tb/tb_ul4_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ul4_arbiter.sv
// Round-robin front end that shares one ul4 logic unit between two requesters.
// Valid/ready on both sides: a transfer happens on a rising edge where valid && ready are both high.
module ul4_arbiter #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_s,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_s,
    output logic             req1_ready,
    output logic [WIDTH-1:0] ul_a,
    output logic [WIDTH-1:0] ul_b,
    output logic [1:0]       ul_s,
    input  logic [WIDTH-1:0] ul_out,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    input  logic             res_ready,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               prio_q, prio_d;
    logic [WIDTH-1:0]   ul_a_q, ul_a_d;
    logic [WIDTH-1:0]   ul_b_q, ul_b_d;
    logic [1:0]         ul_s_q, ul_s_d;
    logic               res_valid_q, res_valid_d;
    logic [WIDTH-1:0]   res_data_q, res_data_d;
    logic               res_id_q, res_id_d;
    logic [CNT_W-1:0]   ops_done_q, ops_done_d;

    logic               grant1;
    logic               accept;

    // Requester 1 wins when it is alone, or when both ask and it holds priority.
    assign grant1 = req1_valid && (!req0_valid || prio_q);
    assign accept = req0_ready || req1_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = HOLD;
            HOLD:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        // Readies are masked by rst_n so nothing is offered while reset is held.
        if (rst_n && (state_q == IDLE)) begin
            req0_ready = req0_valid && !grant1;
            req1_ready = grant1;
        end
        busy      = (state_q != IDLE);
        state_dbg = state_q;
    end

    always_comb begin
        prio_d      = prio_q;
        ul_a_d      = ul_a_q;
        ul_b_d      = ul_b_q;
        ul_s_d      = ul_s_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        ops_done_d  = ops_done_q;
        if (accept) begin
            ul_a_d   = grant1 ? req1_a : req0_a;
            ul_b_d   = grant1 ? req1_b : req0_b;
            ul_s_d   = grant1 ? req1_s : req0_s;
            res_id_d = grant1;
            prio_d   = !grant1;
        end
        if (state_q == EXEC) begin
            res_data_d  = ul_out;
            res_valid_d = 1'b1;
        end
        if ((state_q == HOLD) && res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
            ops_done_d  = ops_done_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q      <= 1'b0;
            ul_a_q      <= '0;
            ul_b_q      <= '0;
            ul_s_q      <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= 1'b0;
            ops_done_q  <= '0;
        end else begin
            prio_q      <= prio_d;
            ul_a_q      <= ul_a_d;
            ul_b_q      <= ul_b_d;
            ul_s_q      <= ul_s_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            ops_done_q  <= ops_done_d;
        end
    end

    assign ul_a      = ul_a_q;
    assign ul_b      = ul_b_q;
    assign ul_s      = ul_s_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_ul4_arbiter.sv
// Bench for ul4_arbiter: a ul4 stub, directed plus random traffic, and a negedge
// reference model whose expected results queue is drained by the result monitor.
module tb_ul4_arbiter;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             req0_valid, req1_valid;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]       req0_s, req1_s;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] ul_a, ul_b, ul_out;
    logic [1:0]       ul_s;
    logic             res_valid, res_id, res_ready, busy;
    logic [WIDTH-1:0] res_data;
    logic [CNT_W-1:0] ops_done;
    logic [1:0]       state_dbg;

    ul4_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_s(req0_s), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_s(req1_s), .req1_ready(req1_ready),
        .ul_a(ul_a), .ul_b(ul_b), .ul_s(ul_s), .ul_out(ul_out),
        .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .res_ready(res_ready),
        .busy(busy), .ops_done(ops_done), .state_dbg(state_dbg)
    );

    function automatic logic [WIDTH-1:0] ul4_fn(input logic [1:0] s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        case (s)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~a;
        endcase
    endfunction

    // ul4 stub; selector 00 is the AND used by the directed cases
    always_comb ul_out = ul4_fn(ul_s, ul_a, ul_b);

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // reference model state
    logic [WIDTH:0]   exp_q[$];
    int               got_ids[$];
    int               cyc = 0;
    int               acc_cyc = 0;
    int               m_ops = 0;
    int               n_acc = 0;
    bit               outstanding = 0;
    bit               m_prio = 0;
    logic [WIDTH-1:0] m_a = '0;
    logic [WIDTH-1:0] m_b = '0;
    logic [1:0]       m_s = '0;

    bit               e0, e1, e_valid, g_id;
    logic [WIDTH-1:0] g_a, g_b;
    logic [1:0]       g_s;

    // monitor + model: checks every cycle, pops the expected queue on a result handshake
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            outstanding = 0;
            m_prio = 0;
            m_ops = 0;
            m_a = '0;
            m_b = '0;
            m_s = '0;
            chk("rst_ready", {req1_ready, req0_ready}, 0);
            chk("rst_res", {res_valid, res_id, res_data}, 0);
            chk("rst_busy_ops", {busy, ops_done}, 0);
            chk("rst_ul", {ul_a, ul_b, ul_s}, 0);
        end else begin
            cyc++;
            e0 = 0;
            e1 = 0;
            if (!outstanding) begin
                if (req0_valid && req1_valid) begin
                    e1 = m_prio;
                    e0 = !m_prio;
                end else begin
                    e0 = req0_valid;
                    e1 = req1_valid;
                end
            end
            e_valid = outstanding && (cyc >= acc_cyc + 2);
            chk("ready", {req1_ready, req0_ready}, {e1, e0});
            chk("ul_regs", {ul_a, ul_b, ul_s}, {m_a, m_b, m_s});
            chk("busy", busy, outstanding);
            chk("res_valid", res_valid, e_valid);
            chk("ops_done", ops_done, m_ops % (1 << CNT_W));
            if (res_valid && exp_q.size() > 0)
                chk("res_id_data", {res_id, res_data}, exp_q[0]);
            if (e_valid && res_valid && res_ready) begin
                got_ids.push_back(int'(res_id));
                void'(exp_q.pop_front());
                m_ops++;
                outstanding = 0;
            end
            if (e0 || e1) begin
                g_id = e1;
                g_a = g_id ? req1_a : req0_a;
                g_b = g_id ? req1_b : req0_b;
                g_s = g_id ? req1_s : req0_s;
                exp_q.push_back({g_id, ul4_fn(g_s, g_a, g_b)});
                m_a = g_a;
                m_b = g_b;
                m_s = g_s;
                m_prio = !g_id;
                outstanding = 1;
                acc_cyc = cyc;
                n_acc++;
            end
        end
    end

    // driver tasks
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [1:0] s);
        int start;
        bit ok;
        start = n_acc;
        ok = 0;
        if (id) begin
            req1_valid = 1; req1_a = a; req1_b = b; req1_s = s;
        end else begin
            req0_valid = 1; req0_a = a; req0_b = b; req0_s = s;
        end
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (n_acc != start) begin
                ok = 1;
                break;
            end
        end
        if (id) req1_valid = 0;
        else req0_valid = 0;
        chk("issue_accepted", ok, 1);
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (!busy && !outstanding && exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        chk("wait_idle", ok, 1);
    endtask

    task automatic wait_res_valid(input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (res_valid) begin
                ok = 1;
                break;
            end
        end
        chk("wait_res_valid", ok, 1);
    endtask

    task automatic reset_pulse();
        rst_n = 0;
        repeat (2) cycle();
    endtask

    initial begin
        rst_n = 0;
        req0_valid = 0; req0_a = '0; req0_b = '0; req0_s = '0;
        req1_valid = 0; req1_a = '0; req1_b = '0; req1_s = '0;
        res_ready = 0;
        repeat (3) cycle();
        rst_n = 1;
        repeat (3) cycle();
        chk("idle_outputs", {res_valid, busy, ops_done, ul_a}, 0);

        // single request
        res_ready = 1;
        issue(0, 4'b1100, 4'b1010, 2'b00);
        chk("single_ul_a", ul_a, 4'b1100);
        wait_idle(20);
        chk("single_ops", ops_done, 1);

        // contention from reset: alternating grants
        reset_pulse();
        req0_valid = 1; req0_a = 4'b1111; req0_b = 4'b0101; req0_s = 2'b00;
        req1_valid = 1; req1_a = 4'b0011; req1_b = 4'b0110; req1_s = 2'b00;
        got_ids.delete();
        rst_n = 1;
        for (int i = 0; i < 60 && got_ids.size() < 6; i++) cycle();
        req0_valid = 0;
        req1_valid = 0;
        chk("contention_count", got_ids.size(), 6);
        for (int i = 0; i < 6 && i < got_ids.size(); i++) chk("contention_id", got_ids[i], i % 2);
        wait_idle(20);

        // backpressure with the other requester waiting
        res_ready = 0;
        issue(0, 4'b0110, 4'b1011, 2'b10);
        req1_valid = 1; req1_a = 4'b1001; req1_b = 4'b0011; req1_s = 2'b01;
        wait_res_valid(10);
        repeat (5) cycle();
        chk("bp_held", {res_valid, res_id, res_data}, {1'b1, 1'b0, 4'b1101});
        res_ready = 1;
        begin
            int start;
            start = n_acc;
            for (int i = 0; i < 10 && n_acc == start; i++) cycle();
            req1_valid = 0;
        end
        wait_idle(20);

        // reset during HOLD
        res_ready = 0;
        issue(1, 4'b1001, 4'b0011, 2'b01);
        wait_res_valid(10);
        cycle();
        rst_n = 0;
        #1;
        chk("async_rst_res_valid", res_valid, 0);
        chk("async_rst_ops_id_busy", {ops_done, res_id, busy}, 0);
        repeat (2) cycle();
        rst_n = 1;
        got_ids.delete();
        res_ready = 1;
        req0_valid = 1; req0_a = 4'(($urandom_range(0, 15))); req0_b = 4'($urandom_range(0, 15)); req0_s = 2'($urandom_range(0, 3));
        req1_valid = 1; req1_a = 4'($urandom_range(0, 15)); req1_b = 4'($urandom_range(0, 15)); req1_s = 2'($urandom_range(0, 3));
        for (int i = 0; i < 20 && got_ids.size() < 1; i++) cycle();
        req0_valid = 0;
        req1_valid = 0;
        chk("post_rst_first_id", (got_ids.size() > 0) ? got_ids[0] : -1, 0);
        wait_idle(20);

        // counter wrap after 256 results
        reset_pulse();
        rst_n = 1;
        res_ready = 1;
        for (int i = 0; i < 1000 && m_ops < 256; i++) begin
            req0_valid = 1; req0_a = 4'($urandom_range(0, 15)); req0_b = 4'($urandom_range(0, 15)); req0_s = 2'($urandom_range(0, 3));
            req1_valid = 1; req1_a = 4'($urandom_range(0, 15)); req1_b = 4'($urandom_range(0, 15)); req1_s = 2'($urandom_range(0, 3));
            cycle();
        end
        req0_valid = 0;
        req1_valid = 0;
        wait_idle(20);
        chk("wrap_ops_done", ops_done, 0);

        // random traffic with random backpressure and dropped requests
        for (int c = 0; c < 400; c++) begin
            res_ready = ($urandom_range(0, 3) != 0);
            req0_valid = ($urandom_range(0, 3) != 0);
            req0_a = 4'($urandom_range(0, 15)); req0_b = 4'($urandom_range(0, 15)); req0_s = 2'($urandom_range(0, 3));
            req1_valid = ($urandom_range(0, 3) != 0);
            req1_a = 4'($urandom_range(0, 15)); req1_b = 4'($urandom_range(0, 15)); req1_s = 2'($urandom_range(0, 3));
            cycle();
        end
        req0_valid = 0;
        req1_valid = 0;
        res_ready = 1;
        wait_idle(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
